rob: RTL and testbench

Reorder buffer for the out-of-order core, at the far end of the rename/ROB interface. It accepts renamed instructions (tag, old/new destination PREG) from the rename stage and records execution completions. It retires entries in program order, returning each retired instruction's previous destination PREG to the rename free list. On a branch misprediction it squashes younger entries and pulses the recovery request back to rename.

---
 rtl/rob.sv | 88 ++++++++
 tb/tb_rob.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/rob.sv
// rob: in-order retirement of renamed instructions, with completion tracking and
// branch-mispredict squash that pulses recovery back to rename.
module rob #(
  parameter int DEPTH = 64,
  parameter int ROB_TAG_W = 6,
  parameter int N_PHYS = 64,
  localparam int PW = $clog2(N_PHYS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_valid_i,
  output logic                 alloc_ready_o,
  input  logic [ROB_TAG_W-1:0] alloc_tag_i,
  input  logic                 alloc_rd_used_i,
  input  logic [PW-1:0]        alloc_rd_old_p_i,
  input  logic [PW-1:0]        alloc_rd_new_p_i,
  input  logic                 wb_valid_i,
  input  logic [ROB_TAG_W-1:0] wb_tag_i,
  input  logic                 br_mispredict_i,
  input  logic [ROB_TAG_W-1:0] br_tag_i,
  output logic                 commit_valid_o,
  output logic [ROB_TAG_W-1:0] commit_tag_o,
  output logic                 commit_free_valid_o,
  output logic [PW-1:0]        commit_free_preg_o,
  output logic                 recover_o,
  output logic [ROB_TAG_W:0]   count_o,
  output logic                 alloc_err_o
);
  localparam logic [ROB_TAG_W:0] FULL = (ROB_TAG_W+1)'(DEPTH);
  logic [DEPTH-1:0] r_valid, r_done, w_valid_n, w_done_n, w_sq;
  logic [2*PW:0] r_pay [DEPTH];
  logic [ROB_TAG_W-1:0] r_head, r_tail, w_off_b;
  logic [ROB_TAG_W:0] r_count;
  logic w_br_live, w_commit, w_alloc;
  assign count_o = r_count;
  assign alloc_ready_o = (r_count < FULL) && !br_mispredict_i;
  assign w_br_live = br_mispredict_i && r_valid[br_tag_i];
  assign w_alloc = alloc_valid_i && alloc_ready_o;
  assign w_commit = (r_count != '0) && r_valid[r_head] && r_done[r_head] && !w_br_live;
  assign w_off_b = br_tag_i - r_head;
  // An entry is younger than the branch when its distance from head exceeds the branch's.
  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      w_sq[i] = w_br_live && r_valid[i] && (ROB_TAG_W'(ROB_TAG_W'(i) - r_head) > w_off_b);
    w_valid_n = r_valid & ~w_sq;
    w_done_n = r_done;
    if (wb_valid_i && r_valid[wb_tag_i] && !w_sq[wb_tag_i]) w_done_n[wb_tag_i] = 1'b1;
    if (w_br_live) w_done_n[br_tag_i] = 1'b1;
    if (w_commit) w_valid_n[r_head] = 1'b0;
    if (w_alloc) begin
      w_valid_n[r_tail] = 1'b1;
      w_done_n[r_tail] = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_done <= '0;
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
      commit_valid_o <= 1'b0;
      commit_tag_o <= '0;
      commit_free_valid_o <= 1'b0;
      commit_free_preg_o <= '0;
      recover_o <= 1'b0;
      alloc_err_o <= 1'b0;
    end else begin
      r_valid <= w_valid_n;
      r_done <= w_done_n;
      r_head <= w_commit ? r_head + 1'b1 : r_head;
      r_tail <= w_br_live ? br_tag_i + 1'b1 : (w_alloc ? r_tail + 1'b1 : r_tail);
      r_count <= w_br_live ? (ROB_TAG_W+1)'(w_off_b) + 1'b1
               : r_count + (ROB_TAG_W+1)'(w_alloc) - (ROB_TAG_W+1)'(w_commit);
      commit_valid_o <= w_commit;
      commit_free_valid_o <= w_commit && r_pay[r_head][2*PW];
      recover_o <= w_br_live;
      if (w_commit) begin
        commit_tag_o <= r_head;
        commit_free_preg_o <= r_pay[r_head][PW-1:0];
      end
      if (w_alloc && alloc_tag_i != r_tail) alloc_err_o <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (w_alloc) r_pay[r_tail] <= {alloc_rd_used_i, alloc_rd_new_p_i, alloc_rd_old_p_i};
  end
endmodule

// File: tb/tb_rob.sv
// tb_rob: randomized and directed stimulus against a queue-based program-order model,
// with a per-cycle scoreboard consumed by an independent monitor.
module tb_rob;
  logic clk = 0, rst = 1;
  logic av = 0, used = 0, wbv = 0, brv = 0;
  logic [5:0] atag = 0, oldp = 0, newp = 0, wbt = 0, brt = 0;
  logic ready, cv, fv, rec, err;
  logic [5:0] ctag, preg;
  logic [6:0] cnt;
  typedef struct {logic [5:0] tag; bit used; logic [5:0] oldp; bit done;} ent_t;
  typedef struct {bit cv; logic [5:0] tag; bit fv; logic [5:0] preg; bit rec; int cnt; bit err;} exp_t;
  ent_t q[$];
  exp_t sb[$];
  logic [5:0] mtail = 0;
  bit merr = 0;
  int total = 0, bad = 0;

  rob dut (.clk(clk), .rst(rst), .alloc_valid_i(av), .alloc_ready_o(ready), .alloc_tag_i(atag),
    .alloc_rd_used_i(used), .alloc_rd_old_p_i(oldp), .alloc_rd_new_p_i(newp),
    .wb_valid_i(wbv), .wb_tag_i(wbt), .br_mispredict_i(brv), .br_tag_i(brt),
    .commit_valid_o(cv), .commit_tag_o(ctag), .commit_free_valid_o(fv), .commit_free_preg_o(preg),
    .recover_o(rec), .count_o(cnt), .alloc_err_o(err));

  always #5 clk = ~clk;

  function automatic void chk(string n, int a, int x);
    total++;
    if (a != x) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", n, a, x, $time);
    end
  endfunction

  task automatic cyc(input bit a_v, input logic [5:0] a_t, input bit a_u, input logic [5:0] a_o,
                     input bit w_v, input logic [5:0] w_t, input bit b_v, input logic [5:0] b_t);
    exp_t e;
    int k;
    bit hd, rdy, live;
    @(negedge clk);
    av = a_v; atag = a_t; used = a_u; oldp = a_o; newp = 6'($urandom);
    wbv = w_v; wbt = w_t; brv = b_v; brt = b_t;
    #1;
    rdy = q.size() < 64 && !b_v;
    chk("alloc_ready", ready, rdy);
    e = '{default: 0};
    k = -1;
    foreach (q[j]) if (q[j].tag == b_t) k = j;
    live = b_v && k >= 0;
    e.rec = live;
    if (live) begin
      q = q[0:k];
      q[k].done = 1;
      if (w_v) foreach (q[j]) if (q[j].tag == w_t) q[j].done = 1;
      mtail = b_t + 6'd1;
    end else begin
      hd = q.size() > 0 && q[0].done;
      if (w_v) foreach (q[j]) if (q[j].tag == w_t) q[j].done = 1;
      if (hd) begin
        e.cv = 1; e.tag = q[0].tag; e.fv = q[0].used; e.preg = q[0].oldp;
        void'(q.pop_front());
      end
      if (a_v && rdy) begin
        if (a_t != mtail) merr = 1;
        q.push_back('{mtail, a_u, a_o, 1'b0});
        mtail++;
      end
    end
    e.cnt = q.size();
    e.err = merr;
    sb.push_back(e);
  endtask

  task automatic idle();
    cyc(0, mtail, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic alloc(input bit u, input logic [5:0] o);
    cyc(1, mtail, u, o, 0, 0, 0, 0);
  endtask

  task automatic wb(input logic [5:0] t);
    cyc(0, mtail, 0, 0, 1, t, 0, 0);
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && q.size() > 0; n++) begin
      int j = -1;
      foreach (q[i]) if (j < 0 && !q[i].done) j = i;
      if (j >= 0) wb(q[j].tag); else idle();
    end
    idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; av = 0; wbv = 0; brv = 0;
    q.delete(); sb.delete(); mtail = 0; merr = 0;
    #2;
    chk("rst_count", cnt, 0);
    chk("rst_commit_valid", cv, 0);
    chk("rst_free_valid", fv, 0);
    chk("rst_recover", rec, 0);
    chk("rst_err", err, 0);
    chk("rst_tag", ctag, 0);
    chk("rst_preg", preg, 0);
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  function automatic logic [5:0] pick();
    return (q.size() > 0 && $urandom % 4 != 0) ? q[$urandom % q.size()].tag : 6'($urandom);
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("commit_valid", cv, e.cv);
        chk("free_valid", fv, e.fv);
        chk("recover", rec, e.rec);
        chk("count", cnt, e.cnt);
        chk("alloc_err", err, e.err);
        if (e.cv) begin
          chk("commit_tag", ctag, e.tag);
          chk("free_preg", preg, e.preg);
        end
      end
    end
  end

  initial begin : stim
    logic [5:0] t7;
    do_reset();
    alloc(1, 5); alloc(1, 6); alloc(1, 7);
    wb(2); wb(0); wb(1);
    repeat (3) idle();
    for (int i = 0; i < 64; i++) alloc(1, 6'($urandom));
    alloc(1, 1);
    cyc(1, mtail, 1, 1, 1, q[0].tag, 0, 0);
    alloc(1, 2);
    alloc(1, 3);
    drain();
    for (int i = 0; i < 10; i++) alloc(1, 6'(i));
    t7 = q[7].tag;
    cyc(0, mtail, 0, 0, 0, 0, 1, q[3].tag);
    wb(t7);
    alloc(1, 9);
    drain();
    alloc(1, 11); alloc(1, 12);
    wb(q[0].tag);
    cyc(1, mtail, 1, 13, 0, 0, 1, q[1].tag);
    idle(); idle();
    drain();
    alloc(0, 20);
    wb(q[0].tag);
    idle(); idle();
    for (int p = 0; p < 8; p++)
      for (int n = 0; n < 500; n++)
        cyc($urandom % 10 < 7, mtail, 1'($urandom), 6'($urandom),
            $urandom % 100 < ((p % 2) ? 15 : 60), pick(), $urandom % 50 == 0, pick());
    drain();
    do_reset();
    alloc(1, 1); alloc(1, 2);
    cyc(1, 6'd9, 1, 3, 0, 0, 0, 0);
    alloc(1, 4);
    wb(q[0].tag);
    repeat (3) idle();
    do_reset();
    repeat (2) idle();
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
